// File: rtl/add_sub_acc.sv
// rtl/add_sub_acc.sv - registered ADD/SUB/ACC/CLR stage on a ripple adder with valid/ready on both sides
// Holds one result; a new beat may enter in the same cycle the held result is consumed.

module add_sub_ripple #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[W];
endmodule

module add_sub_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   result,
    output logic         zero,
    output logic [W-1:0] acc_out
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    logic [0:0]   state;
    logic [0:0]   state_nx;
    logic [W-1:0] acc_q;
    logic         accept;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W:0]   result_nx;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign acc_out   = acc_q;

    // SUB is two's complement: invert b and inject the +1 as carry-in.
    always_comb begin
        opa = a;
        opb = b;
        cin = 1'b0;
        case (op)
            OP_SUB: begin
                opb = ~b;
                cin = 1'b1;
            end
            OP_ACC: begin
                opa = acc_q;
                opb = a;
            end
            default: ;
        endcase
    end

    add_sub_ripple #(.W(W)) u_adder (
        .x    (opa),
        .y    (opb),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    assign result_nx = (op == OP_CLR) ? '0 : {cout, sum};

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY:   if (accept) state_nx = FULL;
            FULL:    if (out_ready && !accept) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            result <= '0;
            zero   <= 1'b1;
            acc_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                result <= result_nx;
                zero   <= (result_nx[W-1:0] == '0);
                if (op == OP_ACC) acc_q <= sum;
                if (op == OP_CLR) acc_q <= '0;
            end
        end
    end
endmodule
